// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive-path controller.
// The optional idle-timeout interrupt is enabled by defining UART_RX_TIMEOUT_EN.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    S_DISABLED,
    S_IDLE,
    S_ACTIVE,
    S_STORE
  } rx_state_e;

  localparam int RX_DATA_W = 32;

  typedef struct packed {
    logic                 err;
    logic [RX_DATA_W-1:0] data;
  } rx_entry_t;

  // Four 16x-oversampled character times of a DATA_WIDTH/8-byte word plus start/stop.
  function automatic int timeout_ticks(input int dw);
    return 4 * 16 * (dw / 8 + 2);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// The head is registered, so a pop or first write shows on rd_data one cycle later.
module uart_rx_fifo #(
  parameter  int W     = 33,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count,
  output logic          overrun
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [W-1:0]  r_head;
  logic          w_wr, w_rd;
  logic [AW-1:0] w_rd_nxt;

  assign empty    = (r_count == '0);
  assign full     = (r_count == FULL_CNT);
  assign w_rd     = rd_en && !empty;
  // A full FIFO still accepts a write when the head is popped in the same cycle.
  assign w_wr     = wr_en && (!full || rd_en);
  assign overrun  = wr_en && full && !rd_en;
  assign w_rd_nxt = r_rd_ptr + 1'b1;
  assign count    = r_count;
  assign rd_data  = r_head;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= w_rd_nxt;
      r_count <= r_count + CW'(w_wr) - CW'(w_rd);
      // Next head comes from memory unless it is the word being written right now.
      if (w_rd) begin
        if (r_count > CW'(1))  r_head <= r_mem[w_rd_nxt];
        else if (w_wr)         r_head <= wr_data;
      end else if (w_wr && empty) begin
        r_head <= wr_data;
      end
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive-path controller: baud tick divider, RX synchroniser, frame FSM,
// receive FIFO, sticky errors and interrupt. Optional timeout via UART_RX_TIMEOUT_EN.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int FIFO_DEPTH = 8,
  parameter  int DIV_WIDTH  = 16,
  localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  rx_en,
  input  logic [DIV_WIDTH-1:0]  baud_div,
  input  logic                  rx_pin,
  output logic                  rx_line,
  output logic                  rx_tick,
  output logic                  rx_detect,
  input  logic                  rx_done,
  input  logic                  rx_error,
  input  logic [DATA_WIDTH-1:0] rx_data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_err,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  output logic [CW-1:0]         fifo_count,
  input  logic [CW-1:0]         irq_level,
  input  logic                  err_clr,
  output logic                  overrun_err,
  output logic                  parity_err,
  output logic                  rx_busy,
  output logic                  irq
);

  logic [DIV_WIDTH-1:0]  r_div_cnt;
  logic                  r_tick;
  logic [1:0]            r_sync;
  rx_state_e             r_state;
  logic                  r_detect, r_busy, r_pend, r_done_d;
  logic [DATA_WIDTH-1:0] r_hold;
  logic                  r_hold_err;
  logic                  r_ovr, r_par, r_irq;

  logic [DIV_WIDTH-1:0]  w_div_last;
  logic                  w_done_rise, w_wr, w_ovf, w_empty, w_full, w_lvl, w_to;
  logic [DATA_WIDTH:0]   w_head;
  logic [CW-1:0]         w_count;

  assign w_div_last  = (baud_div == '0) ? '0 : baud_div - 1'b1;
  assign w_done_rise = rx_done && !r_done_d;
  assign w_wr        = (r_state == S_STORE) && rx_en;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_div_cnt <= '0;
      r_tick    <= 1'b0;
    end else if (!rx_en) begin
      r_div_cnt <= '0;
      r_tick    <= 1'b0;
    end else if (r_div_cnt >= w_div_last) begin
      r_div_cnt <= '0;
      r_tick    <= 1'b1;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
      r_tick    <= 1'b0;
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) r_sync <= 2'b11;
    else        r_sync <= {r_sync[0], rx_pin};
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state    <= S_DISABLED;
      r_detect   <= 1'b0;
      r_busy     <= 1'b0;
      r_pend     <= 1'b0;
      r_done_d   <= 1'b0;
      r_hold     <= '0;
      r_hold_err <= 1'b0;
    end else begin
      r_done_d <= rx_done;
      if (!rx_en) begin
        r_state  <= S_DISABLED;
        r_detect <= 1'b0;
        r_busy   <= 1'b0;
        r_pend   <= 1'b0;
      end else begin
        case (r_state)
          S_DISABLED: begin
            r_state  <= S_IDLE;
            r_detect <= 1'b1;
          end
          S_IDLE: if (r_tick && !r_sync[1]) begin
            r_state  <= S_ACTIVE;
            r_detect <= 1'b0;
            r_busy   <= 1'b1;
          end
          S_ACTIVE: begin
            // An error seen in the completing cycle still belongs to this word.
            if (w_done_rise) begin
              r_state    <= S_STORE;
              r_busy     <= 1'b0;
              r_hold     <= rx_data_in;
              r_hold_err <= r_pend | rx_error;
            end else if (rx_error) begin
              r_pend <= 1'b1;
            end
          end
          default: begin
            r_state  <= S_IDLE;
            r_detect <= 1'b1;
            r_pend   <= 1'b0;
          end
        endcase
      end
    end
  end

  uart_rx_fifo #(.W(DATA_WIDTH + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (PCLK),
    .rst     (PRESET),
    .wr_en   (w_wr),
    .wr_data ({r_hold_err, r_hold}),
    .rd_en   (rd_en),
    .rd_data (w_head),
    .empty   (w_empty),
    .full    (w_full),
    .count   (w_count),
    .overrun (w_ovf)
  );

`ifdef UART_RX_TIMEOUT_EN
  localparam int TO_TICKS = timeout_ticks(DATA_WIDTH);
  localparam int TOW      = $clog2(TO_TICKS + 1);

  logic [TOW-1:0] r_to_cnt;
  logic           r_timeout;
  logic           w_pop, w_to_inc, w_to_hit;

  assign w_pop    = rd_en && !w_empty;
  assign w_to_inc = r_tick && !w_empty && (r_state == S_IDLE) && (r_to_cnt != TOW'(TO_TICKS));
  assign w_to_hit = w_to_inc && (r_to_cnt == TOW'(TO_TICKS - 1)) && !w_wr && !w_pop;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_to_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (w_wr || w_pop) r_to_cnt <= '0;
      else if (w_to_inc) r_to_cnt <= r_to_cnt + 1'b1;
      if (w_to_hit)                r_timeout <= 1'b1;
      else if (err_clr || w_pop)   r_timeout <= 1'b0;
    end
  end

  assign w_to = r_timeout;
`else
  assign w_to = 1'b0;
`endif

  assign w_lvl = (irq_level != '0) && (w_count >= irq_level);

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_ovr <= 1'b0;
      r_par <= 1'b0;
      r_irq <= 1'b0;
    end else begin
      if (w_ovf)        r_ovr <= 1'b1;
      else if (err_clr) r_ovr <= 1'b0;
      if (w_wr && r_hold_err) r_par <= 1'b1;
      else if (err_clr)       r_par <= 1'b0;
      r_irq <= w_lvl | r_ovr | r_par | w_to;
    end
  end

  assign rx_line     = r_sync[1];
  assign rx_tick     = r_tick;
  assign rx_detect   = r_detect;
  assign rx_busy     = r_busy;
  assign rd_data     = w_head[DATA_WIDTH-1:0];
  assign rd_err      = w_head[DATA_WIDTH];
  assign fifo_empty  = w_empty;
  assign fifo_full   = w_full;
  assign fifo_count  = w_count;
  assign overrun_err = r_ovr;
  assign parity_err  = r_par;
  assign irq         = r_irq;

endmodule
